// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fills one cache block on a miss.
//
// When a miss is seen while idle, the FSM latches the block base address. It
// then issues one main-memory read per word on back-to-back cycles. Each
// returned word is written into the data array in the same cycle it arrives.
// The tag array is written together with the last word. The requester is
// stalled (fsm_busy) for the whole fill.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   miss_detected      cache lookup missed this cycle
//   miss_address       byte address of the missing access
//   fsm_busy           fill in progress, stall the requester
//   mem_read_en        read request to main memory this cycle
//   memory_address     byte address of the current read request
//   memory_data_valid  one word returned this cycle (in request order)
//   memory_data        returned word
//   write_data_array   write fill_data at fill_address
//   fill_address       byte address of the returned word
//   fill_word_idx      word index of the returned word within the block
//   fill_data          returned word (pass-through)
//   write_tag_array    write tag/valid for the block at fill_address
module cache_fill_fsm #(
  parameter  int BLOCK_WORDS = 8,
  parameter  int ADDR_W      = 16,
  localparam int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic [IDX_W-1:0]  fill_word_idx,
  output logic [15:0]       fill_data,
  output logic              write_tag_array
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [IDX_W:0]    NWORDS    = (IDX_W+1)'(BLOCK_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);
  // Words are 2 bytes, so the block offset spans IDX_W+1 address bits.
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << (IDX_W + 1)) - 1);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [IDX_W:0]    issueCnt;   // saturates at BLOCK_WORDS
  logic [IDX_W-1:0]  recvCnt;
  logic              issuing;
  logic              lastWord;
  logic [IDX_W-1:0]  issueIdx;

  assign issuing  = (state == FILL) && (issueCnt < NWORDS);
  assign lastWord = (recvCnt == LAST_IDX);
  // Once all reads are out, issueCnt sits at BLOCK_WORDS (top bit set).
  // The request address then stays on the last word instead of stepping
  // past the block.
  assign issueIdx = issueCnt[IDX_W] ? LAST_IDX : issueCnt[IDX_W-1:0];

  // Request side: registers only, no path from any input.
  assign fsm_busy       = (state == FILL);
  assign mem_read_en    = issuing;
  assign memory_address = base + ADDR_W'({issueIdx, 1'b0});

  // Return side: qualified directly by memory_data_valid.
  assign write_data_array = (state == FILL) && memory_data_valid;
  assign write_tag_array  = write_data_array && lastWord;
  assign fill_address     = base + ADDR_W'({recvCnt, 1'b0});
  assign fill_word_idx    = recvCnt;
  assign fill_data        = memory_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      issueCnt <= '0;
      recvCnt  <= '0;
    end else if (state == IDLE) begin
      // Returns that arrive while idle (e.g. left over from an aborted fill)
      // are ignored.
      if (miss_detected) begin
        base     <= miss_address & BASE_MASK;
        issueCnt <= '0;
        recvCnt  <= '0;
        state    <= FILL;
      end
    end else begin
      if (issuing) issueCnt <= issueCnt + (IDX_W+1)'(1);
      if (memory_data_valid) begin
        recvCnt <= recvCnt + IDX_W'(1);
        // A new miss is never taken here, even on the last word. It is
        // taken on the first idle cycle that follows.
        if (lastWord) state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic [15:0] fill_address;
  logic [2:0]  fill_word_idx;
  logic [15:0] fill_data;
  logic        write_tag_array;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .fsm_busy(fsm_busy), .mem_read_en(mem_read_en), .memory_address(memory_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .write_data_array(write_data_array), .fill_address(fill_address),
    .fill_word_idx(fill_word_idx), .fill_data(fill_data),
    .write_tag_array(write_tag_array)
  );

  // Present a miss for one cycle; returns in cycle T+1 (the first FILL cycle).
  task automatic startMiss(input logic [15:0] a);
    miss_detected = 1'b1;
    miss_address  = a;
    @(posedge clk); #1;
    miss_detected = 1'b0;
  endtask

  // Runs one fill from cycle T+1. Word w returns in cycle 5 + w*(gap+1),
  // carrying 0xA000+w. Reads are expected in cycles 1..8. missA is driven
  // before the last-word cycle, and missB from that cycle on.
  task automatic doFill(input logic [15:0] expBase, input int gap,
                        input logic holdMiss, input logic [15:0] missA,
                        input logic [15:0] missB);
    int last = 5 + 7 * (gap + 1);
    int rdCount = 0;
    for (int c = 1; c <= last + 1; c++) begin
      logic v;
      int w;
      w = (c - 5) / (gap + 1);
      v = (c >= 5) && ((c - 5) % (gap + 1) == 0) && (w < 8);
      memory_data_valid = v;
      memory_data       = v ? 16'hA000 + 16'(w) : 16'h5555;
      miss_detected     = holdMiss;
      miss_address      = (c < last) ? missA : missB;
      #1;
      total++;
      if (fsm_busy !== (c <= last)) begin
        bad++; $display("FAIL busy c=%0d got=%b exp=%b", c, fsm_busy, (c <= last));
      end
      total++;
      if (mem_read_en !== (c <= 8)) begin
        bad++; $display("FAIL rd_en c=%0d got=%b exp=%b", c, mem_read_en, (c <= 8));
      end
      if (mem_read_en) rdCount++;
      if (c <= 8) begin
        total++;
        if (memory_address !== expBase + 16'(2 * (c - 1))) begin
          bad++; $display("FAIL mem_addr c=%0d got=%h exp=%h", c, memory_address, expBase + 16'(2 * (c - 1)));
        end
      end
      total++;
      if (write_data_array !== v) begin
        bad++; $display("FAIL wr_data c=%0d got=%b exp=%b", c, write_data_array, v);
      end
      if (v) begin
        total++;
        if (fill_address !== expBase + 16'(2 * w) || fill_word_idx !== 3'(w) ||
            fill_data !== 16'hA000 + 16'(w)) begin
          bad++; $display("FAIL fill c=%0d got=%h/%0d/%h exp=%h/%0d/%h", c, fill_address,
                          fill_word_idx, fill_data, expBase + 16'(2 * w), w, 16'hA000 + 16'(w));
        end
      end
      total++;
      if (write_tag_array !== (c == last)) begin
        bad++; $display("FAIL wr_tag c=%0d got=%b exp=%b", c, write_tag_array, (c == last));
      end
      @(posedge clk); #1;
    end
    memory_data_valid = 1'b0;
    miss_detected     = 1'b0;
    total++;
    if (rdCount != 8) begin
      bad++; $display("FAIL rd_count got=%0d exp=8", rdCount);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data_valid = 1'b0; memory_data = 16'h0;
    #3;
    total++;
    if (fsm_busy !== 1'b0 || mem_read_en !== 1'b0 || write_data_array !== 1'b0 ||
        write_tag_array !== 1'b0 || memory_address !== 16'h0 || fill_address !== 16'h0 ||
        fill_word_idx !== 3'd0) begin
      bad++; $display("FAIL reset_vals got=%b%b%b%b %h %h %0d exp=0000 0000 0000 0", fsm_busy,
                      mem_read_en, write_data_array, write_tag_array, memory_address,
                      fill_address, fill_word_idx);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      memory_data_valid = 1'($urandom_range(0, 1));
      memory_data = 16'($urandom);
      #1;
      total++;
      if (fsm_busy !== 1'b0 || mem_read_en !== 1'b0 || write_data_array !== 1'b0 ||
          write_tag_array !== 1'b0) begin
        bad++; $display("FAIL idle c=%0d got=%b%b%b%b exp=0000", c, fsm_busy, mem_read_en,
                        write_data_array, write_tag_array);
      end
      @(posedge clk); #1;
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic test_fill_basic;
    startMiss(16'h1236);
    doFill(16'h1230, 0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_fill_gaps;
    startMiss(16'h1236);
    doFill(16'h1230, 2, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_back_to_back;
    startMiss(16'h2000);
    // Miss stays high through the fill, and switches to 0x3000 from the
    // last-word cycle on. The next fill starts without another startMiss.
    doFill(16'h2000, 0, 1'b1, 16'h2000, 16'h3000);
    doFill(16'h3000, 0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_reset_mid_fill;
    startMiss(16'h4002);
    for (int c = 1; c <= 7; c++) begin
      memory_data_valid = (c >= 5);
      memory_data = 16'hA000 + 16'(c - 5);
      #1;
      total++;
      if (write_data_array !== (c >= 5)) begin
        bad++; $display("FAIL pre_rst_wr c=%0d got=%b exp=%b", c, write_data_array, (c >= 5));
      end
      @(posedge clk); #1;
    end
    memory_data_valid = 1'b1;
    memory_data = 16'hA003;
    rst_n = 1'b0;
    #1;
    total++;
    if (fsm_busy !== 1'b0 || mem_read_en !== 1'b0 || write_data_array !== 1'b0 ||
        write_tag_array !== 1'b0 || memory_address !== 16'h0 || fill_address !== 16'h0 ||
        fill_word_idx !== 3'd0) begin
      bad++; $display("FAIL rst_mid got=%b%b%b%b %h %h %0d exp=0000 0000 0000 0", fsm_busy,
                      mem_read_en, write_data_array, write_tag_array, memory_address,
                      fill_address, fill_word_idx);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int w = 4; w < 8; w++) begin
      memory_data_valid = 1'b1;
      memory_data = 16'hA000 + 16'(w);
      #1;
      total++;
      if (write_data_array !== 1'b0 || write_tag_array !== 1'b0 || fsm_busy !== 1'b0) begin
        bad++; $display("FAIL post_rst w=%0d got=%b%b%b exp=000", w, write_data_array,
                        write_tag_array, fsm_busy);
      end
      @(posedge clk); #1;
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic test_top_of_memory;
    startMiss(16'hFFFE);
    doFill(16'hFFF0, 0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_fill_gaps();
    test_back_to_back();
    test_reset_mid_fill();
    test_top_of_memory();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler between the pipeline's instruction/data cache and the multi-cycle main memory.
- On a cache miss it fetches one whole block from main memory by issuing one read per word on consecutive cycles.
- Each returned word is written into the cache data array; the tag array is written with the last word.
- While it works, the pipeline is stalled (IF or MEM stall) via `fsm_busy`.

Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block. Must be a power of two ≥ 2.
- ADDR_W, 16, byte-address width.
- IDX_W, $clog2(BLOCK_WORDS), word-index width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_detected  in  1  cache lookup missed this cycle.
- miss_address  in  ADDR_W  byte address of the missing access.
- fsm_busy  out  1  fill in progress; stall the requester.
- mem_read_en  out  1  read request to main memory this cycle.
- memory_address  out  ADDR_W  byte address of the current read request.
- memory_data_valid  in  1  main memory returns one word this cycle (in request order).
- memory_data  in  16  returned word.
- write_data_array  out  1  write `fill_data` into the cache data array at `fill_address`.
- fill_address  out  ADDR_W  byte address of the returned word.
- fill_word_idx  out  IDX_W  word index within the block of the returned word.
- fill_data  out  16  equals `memory_data` (combinational pass-through).
- write_tag_array  out  1  write tag/valid for the block at `fill_address`.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Block base: `base = miss_address` with the low log2(BLOCK_WORDS)+1 bits cleared. Default: `miss_address & 16'hFFF0`.
- State: registered `state` {IDLE, FILL}, plus registered `base`, `issue_cnt` (0..BLOCK_WORDS), `recv_cnt` (0..BLOCK_WORDS-1).
- Reset state (async, immediate):
  - state=IDLE, all counters 0, base=0.
  - Outputs: `fsm_busy`=0, `mem_read_en`=0, `write_data_array`=0, `write_tag_array`=0, `memory_address`=0, `fill_address`=0, `fill_word_idx`=0.
- IDLE:
  - `miss_detected`=1 at edge T: latch `base`, clear both counters, go to FILL.
  - `memory_data_valid` in IDLE is ignored (no writes).
- FILL:
  - `fsm_busy`=1.
  - Issue: while `issue_cnt` < BLOCK_WORDS, `mem_read_en`=1 and `memory_address` = base + 2*`issue_cnt`; `issue_cnt` increments each cycle.
  - First request is in cycle T+1; BLOCK_WORDS requests go out back-to-back, with no stall input.
  - After `issue_cnt` reaches BLOCK_WORDS: `mem_read_en`=0 and `memory_address` holds its last value.
  - Receive: when `memory_data_valid`=1:
    - `write_data_array`=1, `fill_address` = base + 2*`recv_cnt`, `fill_word_idx` = `recv_cnt`.
    - `recv_cnt` increments.
  - Valid may arrive with gaps, and may arrive before issue completes.
  - Last word (`recv_cnt`==BLOCK_WORDS-1 and valid): `write_data_array` and `write_tag_array` are both 1 in the same cycle. Next state is IDLE, with `fsm_busy`=0 from the following cycle.
  - `miss_detected` during FILL, including the last-word cycle, is ignored. A still-asserted miss is accepted on the first IDLE cycle.
- Output timing:
  - `fsm_busy`, `mem_read_en`, `memory_address` are decoded from registered state/counters only; no input→output combinational path.
  - `write_data_array`, `write_tag_array`, `fill_*` are combinational from `memory_data_valid` and registers.
- Reset mid-fill: aborts immediately. Partial block is left in the data array with the tag unwritten, so the block stays invalid. Outstanding memory returns after reset are ignored in IDLE.
- Counters never wrap: `issue_cnt` saturates at BLOCK_WORDS. Extra valids are impossible because FILL exits on the last word.

Test Plan:
1. Reset then idle 5 cycles with random `memory_data_valid` → no `write_*` pulses, `fsm_busy`=0, `mem_read_en`=0.
2. miss_address=0x1236 at T, memory model with 4-cycle latency returning 0xA000+i:
   - `memory_address` 0x1230,0x1232,…,0x123E on T+1..T+8, with `mem_read_en` high exactly 8 cycles.
   - `write_data_array` T+5..T+12 with `fill_address` 0x1230+2i and `fill_data` 0xA000+i.
   - `write_tag_array` only at T+12; `fsm_busy` high T+1..T+12.
3. Same miss with the memory model inserting 2-cycle gaps between valids → 8 data writes in order idx 0..7, tag write with idx 7 only, busy held until then.
4. miss_address=0x2000 held asserted throughout a fill, then 0x3000 → second miss ignored during FILL. The next fill starts the cycle after busy drops, with first `memory_address`=0x3000.
5. Assert `rst_n`=0 after 3 returned words → outputs reach their reset values immediately, no tag write. Remaining returns after release produce no writes.
6. miss_address=0xFFFE → base 0xFFF0, addresses 0xFFF0..0xFFFE, no wrap past 0xFFFE.
